// File: rtl/sc_scbc_sofgen.sv
// USB start-of-frame token generator: turns a frame-counter rollover into the
// three-byte SOF token (PID, frame[7:0], {crc5, frame[10:8]}) over a valid/ready byte path.
module sc_scbc_sofgen (
  input  logic        ULPICLK,
  input  logic        ULPIRST,
  input  logic        UPS_OPERATIONAL,
  input  logic        SOF_ENABLE,
  input  logic        FM_ROLLOVER,
  input  logic [15:0] FM_NUMBER,
  input  logic        TX_BUSY,
  output logic [7:0]  SOF_TXDATA,
  output logic        SOF_TXVALID,
  output logic        SOF_TXLAST,
  input  logic        SOF_TXREADY,
  output logic        SOF_BUSY,
  output logic        SOF_MISSED,
  output logic [15:0] SOF_COUNT
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;
  localparam logic [2:0] S_PID  = 3'd2;
  localparam logic [2:0] S_FRM  = 3'd3;
  localparam logic [2:0] S_CRC  = 3'd4;

  logic [2:0]  state_q, state_d;
  logic        rq_q, rq_d;
  logic [10:0] frm_q, frm_d;
  logic [15:0] cnt_q, cnt_d;
  logic        missed_q, missed_d;
  logic        allow, req;
  logic [4:0]  crc_c;
  logic        crc_fb;
  logic [7:0]  crc_byte;
  logic        fm_unused;

  assign fm_unused = ^FM_NUMBER[15:11];
  assign allow     = UPS_OPERATIONAL & SOF_ENABLE;
  assign req       = rq_q & allow;
  assign rq_d      = FM_ROLLOVER;

  // CRC5 over the latched frame, LSB first; combinational so CRC byte is ready with no extra cycle.
  always_comb begin
    crc_c  = 5'h1f;
    crc_fb = 1'b0;
    for (int i = 0; i < 11; i++) begin
      crc_fb = frm_q[i] ^ crc_c[4];
      crc_c  = {crc_c[3:0], 1'b0} ^ (crc_fb ? 5'b00101 : 5'b00000);
    end
  end

  // Inverted CRC sent bit-reversed: c[0] in bit 7 down to c[4] in bit 3.
  assign crc_byte = {~crc_c[0], ~crc_c[1], ~crc_c[2], ~crc_c[3], ~crc_c[4], frm_q[10:8]};

  always_comb begin
    state_d  = state_q;
    frm_d    = frm_q;
    cnt_d    = cnt_q;
    missed_d = req & (state_q != S_IDLE);
    case (state_q)
      S_IDLE: if (req) begin
        state_d = S_WAIT;
        frm_d   = FM_NUMBER[10:0];
      end
      S_WAIT: begin
        if (!allow)        state_d = S_IDLE;
        else if (!TX_BUSY) state_d = S_PID;
      end
      S_PID: if (SOF_TXREADY) state_d = S_FRM;
      S_FRM: if (SOF_TXREADY) state_d = S_CRC;
      S_CRC: if (SOF_TXREADY) begin
        state_d = S_IDLE;
        cnt_d   = cnt_q + 16'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ULPICLK or posedge ULPIRST) begin
    if (ULPIRST) begin
      state_q  <= S_IDLE;
      rq_q     <= 1'b0;
      frm_q    <= 11'd0;
      cnt_q    <= 16'd0;
      missed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rq_q     <= rq_d;
      frm_q    <= frm_d;
      cnt_q    <= cnt_d;
      missed_q <= missed_d;
    end
  end

  always_comb begin
    SOF_TXVALID = 1'b0;
    SOF_TXLAST  = 1'b0;
    SOF_TXDATA  = 8'h00;
    case (state_q)
      S_PID: begin SOF_TXVALID = 1'b1; SOF_TXDATA = 8'hA5; end
      S_FRM: begin SOF_TXVALID = 1'b1; SOF_TXDATA = frm_q[7:0]; end
      S_CRC: begin SOF_TXVALID = 1'b1; SOF_TXLAST = 1'b1; SOF_TXDATA = crc_byte; end
      default: ;
    endcase
  end

  assign SOF_BUSY   = (state_q != S_IDLE);
  assign SOF_MISSED = missed_q;
  assign SOF_COUNT  = cnt_q;

endmodule

// File: tb/tb_sc_scbc_sofgen.sv
// Scoreboard bench for sc_scbc_sofgen: expected token bytes queued at request time,
// popped by a negedge monitor on every valid/ready transfer.
module tb_sc_scbc_sofgen;
  logic        clk = 1'b0, rst = 1'b1;
  logic        ups = 1'b1, en = 1'b1, roll = 1'b0, txbusy = 1'b0, rdy = 1'b1;
  logic [15:0] fmn = 16'h0;
  logic [7:0]  data;
  logic        valid, last, busy, missed;
  logic [15:0] cnt;

  sc_scbc_sofgen dut (
    .ULPICLK(clk), .ULPIRST(rst), .UPS_OPERATIONAL(ups), .SOF_ENABLE(en),
    .FM_ROLLOVER(roll), .FM_NUMBER(fmn), .TX_BUSY(txbusy),
    .SOF_TXDATA(data), .SOF_TXVALID(valid), .SOF_TXLAST(last),
    .SOF_TXREADY(rdy), .SOF_BUSY(busy), .SOF_MISSED(missed), .SOF_COUNT(cnt)
  );

  always #5 clk = ~clk;

  int         n_chk = 0, n_fail = 0;
  int         miss_seen = 0, miss_exp = 0, cnt_exp = 0;
  logic [8:0] exp_q[$];
  bit         rdy_manual = 0, rdy_rand = 0, rdy_force = 0;

  // Reference SOF CRC byte from the frame number using plain integer arithmetic.
  function automatic logic [7:0] ref_crc_byte(int f);
    int c = 31, fb, r = 0;
    for (int i = 0; i < 11; i++) begin
      fb = ((f >> i) & 1) ^ ((c >> 4) & 1);
      c  = ((c << 1) & 31) ^ (fb * 5);
    end
    c = c ^ 31;
    for (int k = 0; k < 5; k++) r = r | (((c >> k) & 1) << (7 - k));
    return 8'(r | ((f >> 8) & 7));
  endfunction

  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Rollover pulse; frame counter shows the post-increment number on the next cycle.
  task automatic rollover(input logic [15:0] fm, input bit push);
    roll = 1'b1;
    cyc(1);
    roll = 1'b0;
    fmn  = fm;
    if (push) begin
      exp_q.push_back({1'b0, 8'hA5});
      exp_q.push_back({1'b0, fm[7:0]});
      exp_q.push_back({1'b1, ref_crc_byte(int'(fm[10:0]))});
      cnt_exp++;
    end
    cyc(1);
  endtask

  task automatic wait_done();
    int t = 0;
    while ((exp_q.size() != 0 || busy) && t < 2000) begin cyc(1); t++; end
    chk("done_timeout", int'(t < 2000), 1);
    chk("sof_count", int'(cnt), cnt_exp);
  endtask

  task automatic wait_valid();
    int t = 0;
    while (!valid && t < 200) begin cyc(1); t++; end
    chk("valid_timeout", int'(t < 200), 1);
  endtask

  always @(posedge clk) begin
    #2;
    rdy = rdy_manual ? rdy_force : (rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1);
  end

  logic       pv = 0, pr = 0;
  logic [8:0] pd = 0;
  logic [8:0] e;
  always @(negedge clk) begin
    if (rst) pv = 0;
    else begin
      if (pv && !pr) begin
        chk("stall_valid", int'(valid), 1);
        chk("stall_data", int'({last, data}), int'(pd));
      end
      chk("last_wo_valid", int'(last & ~valid), 0);
      if (valid && rdy) begin
        if (exp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_byte: got %0h expected none", {last, data});
        end else begin
          e = exp_q.pop_front();
          chk("tx_byte", int'({last, data}), int'(e));
        end
      end
      if (missed) miss_seen++;
      pv = valid; pr = rdy; pd = {last, data};
    end
  end

  initial begin
    logic [15:0] a;
    int v;
    #2;
    chk("rst_valid", int'(valid), 0);
    chk("rst_last", int'(last), 0);
    chk("rst_data", int'(data), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_missed", int'(missed), 0);
    chk("rst_count", int'(cnt), 0);
    cyc(2);
    rst = 1'b0;
    cyc(2);

    // Frame 0: A5 00 10
    rollover(16'h0000, 1);
    wait_done();

    // Random frames, random upper bits and random ready
    rdy_rand = 1;
    for (int i = 0; i < 30; i++) begin
      rollover(16'($urandom), 1);
      wait_done();
    end

    // Transmit path owned by another packet for 50 cycles
    txbusy = 1'b1;
    rollover(16'($urandom), 1);
    v = 0;
    repeat (50) begin cyc(1); if (valid) v++; end
    chk("busy_hold", v, 0);
    txbusy = 1'b0;
    wait_done();
    rdy_rand = 0;

    // Second rollover while held in FRM is dropped
    rdy_manual = 1; rdy_force = 0;
    a = 16'($urandom);
    rollover(a, 1);
    wait_valid();
    rdy_force = 1; cyc(1); rdy_force = 0;
    rollover(a + 16'd1, 0);
    miss_exp++;
    cyc(3);
    rdy_manual = 0;
    wait_done();
    cyc(2);
    chk("missed_pulses", miss_seen, miss_exp);

    // Disabled at rollover: nothing happens
    en = 1'b0;
    rollover(16'($urandom), 0);
    cyc(5);
    chk("en_off_busy", int'(busy), 0);
    en = 1'b1; ups = 1'b0;
    rollover(16'($urandom), 0);
    cyc(5);
    chk("ups_off_busy", int'(busy), 0);
    ups = 1'b1;

    // Enable dropped in WAIT: abandon silently
    txbusy = 1'b1;
    rollover(16'($urandom), 0);
    cyc(3);
    en = 1'b0;
    cyc(2);
    chk("wait_drop_busy", int'(busy), 0);
    txbusy = 1'b0; en = 1'b1;
    cyc(10);
    chk("wait_drop_valid", int'(valid), 0);
    chk("wait_drop_missed", miss_seen, miss_exp);

    // Enable dropped in FRM: token still completes
    rdy_manual = 1; rdy_force = 0;
    rollover(16'($urandom), 1);
    wait_valid();
    rdy_force = 1; cyc(1); rdy_force = 0;
    en = 1'b0; ups = 1'b0;
    cyc(3);
    rdy_manual = 0;
    wait_done();
    en = 1'b1; ups = 1'b1;

    // Async reset while presenting the CRC byte
    rdy_manual = 1; rdy_force = 0;
    rollover(16'($urandom), 1);
    wait_valid();
    rdy_force = 1; cyc(2); rdy_force = 0;
    cyc(1);
    chk("crc_last", int'(last), 1);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("arst_valid", int'(valid), 0);
    chk("arst_last", int'(last), 0);
    chk("arst_data", int'(data), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_count", int'(cnt), 0);
    exp_q.delete();
    cnt_exp = 0;
    #3;
    rst = 1'b0;
    rdy_manual = 0;
    v = 0;
    repeat (10) begin cyc(1); if (valid) v++; end
    chk("post_rst_idle", v, 0);
    rollover(16'($urandom), 1);
    wait_done();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/sc_scbc_sofgen.md
SC_SCBC_SOFGEN -- requirements
Module: sc_scbc_sofgen

Interface
REQ-001 SHALL have no parameters; all widths are fixed.
REQ-002 SHALL have ports:
- ULPICLK  in  1  sole clock; all logic on the rising edge.
- ULPIRST  in  1  reset, asynchronous, active-high.
- UPS_OPERATIONAL  in  1  upstream port operational; SOF generation permitted.
- SOF_ENABLE  in  1  software enable for SOF generation.
- FM_ROLLOVER  in  1  one-cycle frame-interval rollover pulse from the frame counter.
- FM_NUMBER  in  16  frame number from the frame counter; bits [10:0] are used.
- TX_BUSY  in  1  another packet owns the transmit path.
- SOF_TXDATA  out  8  token byte.
- SOF_TXVALID  out  1  SOF_TXDATA is valid.
- SOF_TXLAST  out  1  the current byte is the final byte of the token.
- SOF_TXREADY  in  1  the transmitter accepts the byte.
- SOF_BUSY  out  1  the FSM is not IDLE.
- SOF_MISSED  out  1  one-cycle pulse: SOF request dropped.
- SOF_COUNT  out  16  count of completed SOF tokens.

Function
REQ-003 SHALL register FM_ROLLOVER as rq_d; a request SHALL be raised when rq_d=1 & UPS_OPERATIONAL=1 & SOF_ENABLE=1.
REQ-004 When the request is raised, SHALL latch FM_NUMBER[10:0] into frm (the value one cycle after the rollover, i.e. post-increment).
REQ-005 SHALL implement the FSM states IDLE, WAIT, PID, FRM, CRC.
REQ-006 IDLE: on request -> WAIT (frm latched); otherwise stay.
REQ-007 WAIT: TX_BUSY=0 -> PID; TX_BUSY=1 -> stay (defer indefinitely).
REQ-008 PID: TXVALID=1, TXDATA=0xA5; on TXREADY -> FRM.
REQ-009 FRM: TXVALID=1, TXDATA=frm[7:0]; on TXREADY -> CRC.
REQ-010 CRC: TXVALID=1, TXLAST=1, TXDATA={crc5_tx[4:0], frm[10:8]}; on TXREADY -> IDLE and SOF_COUNT+1.
REQ-011 Handshake: a byte SHALL transfer only on a cycle with TXVALID & TXREADY; TXDATA/TXLAST SHALL hold stable while TXVALID=1 & TXREADY=0; TXVALID SHALL NOT drop before transfer.
REQ-012 TXVALID SHALL be 0 in IDLE and WAIT; TXLAST SHALL be 1 only in CRC.
REQ-013 CRC5: polynomial x^5+x^2+1, seed 5'b11111, frm processed LSB first; per bit fb=bit^c[4], c={c[3:0],0}^(fb?5'b00101:0); the result SHALL be inverted.
REQ-014 crc5_tx SHALL be the inverted CRC bit-reversed so that c[4] lands in TXDATA[3] and c[0] in TXDATA[7]; it SHALL be computed combinationally or by WAIT exit, with no added latency.
REQ-015 Request while the FSM is not IDLE: that request SHALL be dropped, SOF_MISSED=1 for one cycle, and the in-flight token SHALL be unaffected.
REQ-016 SOF_ENABLE or UPS_OPERATIONAL deasserted in PID/FRM/CRC: the token SHALL complete normally.
REQ-017 SOF_ENABLE or UPS_OPERATIONAL deasserted in WAIT: SHALL return to IDLE with no bytes sent and no SOF_MISSED.
REQ-018 SOF_COUNT SHALL wrap from 0xFFFF to 0x0000.
REQ-019 Minimum latency SHALL be: rq_d at cycle N, PID valid at N+2 (IDLE->WAIT->PID) when TX_BUSY=0.

Reset
REQ-020 ULPIRST=1 SHALL force, asynchronously: FSM=IDLE, rq_d=0, frm=0, SOF_TXVALID=0, SOF_TXLAST=0, SOF_TXDATA=0x00, SOF_BUSY=0, SOF_MISSED=0, SOF_COUNT=0.
REQ-021 Reset mid-token SHALL abandon the token; no byte SHALL be presented after reset release until a new request.

Verification
REQ-022 FM_NUMBER=0 after rollover, TXREADY=1 -> bytes A5, 00, 10; TXLAST only on 0x10; SOF_COUNT=1.
REQ-023 Random frames 0..0x7FF vs. a reference CRC5 model -> byte2 matches; frm[10:8] in byte2[2:0]; bits [15:11] ignored.
REQ-024 TX_BUSY=1 for 50 cycles after request -> no TXVALID until TX_BUSY=0, then full token; TXREADY toggled randomly -> data stable while stalled.
REQ-025 Second FM_ROLLOVER while TXREADY=0 holds the FSM in FRM -> SOF_MISSED one pulse, original token completes, SOF_COUNT+1 only.
REQ-026 SOF_ENABLE=0 or UPS_OPERATIONAL=0 at rollover -> no token; drop in WAIT -> IDLE, no bytes; drop in FRM -> token completes.
REQ-027 ULPIRST pulsed asynchronously in CRC -> outputs reset immediately; SOF_COUNT=0; next request produces a full token.
